cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_mon_pkg.sv | 20 ++
 rtl/sat_counter.sv | 20 ++
 rtl/cpu_run_monitor.sv | 113 +++++++++++
 tb/tb_cpu_run_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU run monitor: FSM states, run-status codes and the default
// register-file depth.
package cpu_mon_pkg;

  localparam int NREGS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    HALT    = 2'd1,
    ILLEGAL = 2'd2
  } status_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Runs the CPU until halt/exception, counts run cycles, then streams the register
// file out one entry per beat before reporting done.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int DW    = 32,
  parameter int CW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     start,
  input  logic                     halt,
  input  logic                     exception,
  output logic                     cpu_run,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [DW-1:0]            rf_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NREGS)-1:0] out_idx,
  output logic                     out_last,
  output logic [CW-1:0]            cycles,
  output logic [1:0]               status,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t  state;
  status_t status_q;
  logic    fetching;
  logic    load;
  logic    cnt_clr;
  logic    cnt_en;

  assign status    = status_q;
  assign state_dbg = state;

  // Stream handshake: a beat transfers on any edge where out_valid && out_ready.
  // The single output register refills whenever it is empty or being drained.
  assign load    = (state == DUMP) && fetching && (!out_valid || out_ready);
  assign cnt_clr = ((state == IDLE) || (state == DONE)) && start;
  assign cnt_en  = (state == RUN);

  sat_counter #(.W(CW)) u_cycles (
    .clk (clk),
    .rst (rst_),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (cycles)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= IDLE;
      status_q  <= NONE;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
      fetching  <= 1'b0;
      rf_raddr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            cpu_run  <= 1'b1;
            status_q <= NONE;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (halt || exception) begin
            state    <= DUMP;
            cpu_run  <= 1'b0;
            status_q <= halt ? HALT : ILLEGAL;
            rf_raddr <= '0;
            fetching <= 1'b1;
          end
        end
        DUMP: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= rf_rdata;
            out_idx   <= rf_raddr;
            out_last  <= (rf_raddr == LAST_IDX);
            if (rf_raddr == LAST_IDX) begin
              fetching <= 1'b0;
            end else begin
              rf_raddr <= rf_raddr + 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          // Final beat leaves the register empty and closes the run.
          if (out_valid && out_ready && out_last) begin
            state    <= DONE;
            done     <= 1'b1;
            out_last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: run/halt/exception sequencing, saturating cycle
// count, register dump streaming with back-pressure, and reset abandonment.
module tb_cpu_run_monitor;
  import cpu_mon_pkg::*;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int CW    = 5;
  localparam int AW    = $clog2(NREGS);

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          exception = 1'b0;
  logic          cpu_run;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic [CW-1:0] cycles;
  logic [1:0]    status;
  logic          done;
  logic [1:0]    state_dbg;

  int compared   = 0;
  int mismatched = 0;

  cpu_run_monitor #(.NREGS(NREGS), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .halt      (halt),
    .exception (exception),
    .cpu_run   (cpu_run),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .cycles    (cycles),
    .status    (status),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Register file model: entry i holds i*0x11.
  always_comb rf_rdata = 32'(rf_raddr) * 32'h11;

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drains one full dump; toggle=1 alternates out_ready 1/0 every cycle.
  task automatic collect_dump(input bit toggle);
    int exp_idx;
    exp_idx = 0;
    for (int c = 0; c < 200 && exp_idx < NREGS; c++) begin
      out_ready = toggle ? ~c[0] : 1'b1;
      if (out_valid) begin
        check("beat_idx", 64'(out_idx), 64'(exp_idx));
        check("beat_data", 64'(out_data), 64'(exp_idx * 32'h11));
        check("beat_last", 64'(out_last), 64'(exp_idx == NREGS - 1));
        if (out_ready) exp_idx++;
      end
      step();
    end
    out_ready = 1'b0;
    check("beat_count", 64'(exp_idx), 64'(NREGS));
    check("dump_valid_drop", 64'(out_valid), 64'd0);
    check("dump_done", 64'(done), 64'd1);
    check("dump_state", 64'(state_dbg), 64'(DONE));
    step(2);
    check("no_extra_beat", 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit found;
    // Reset state
    step(2);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_cpu_run", 64'(cpu_run), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    check("rst_status", 64'(status), 64'(NONE));
    check("rst_done", 64'(done), 64'd0);
    check("rst_raddr", 64'(rf_raddr), 64'd0);
    rst_ = 1'b0;

    // Halt after 9 RUN edges, start ignored mid-run
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_entry_cpu_run", 64'(cpu_run), 64'd1);
    check("run_entry_cycles", 64'(cycles), 64'd0);
    step(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    check("run9_cycles", 64'(cycles), 64'd9);
    check("run9_state", 64'(state_dbg), 64'(RUN));
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_cycles", 64'(cycles), 64'd10);
    check("halt_status", 64'(status), 64'(HALT));
    check("halt_cpu_run", 64'(cpu_run), 64'd0);
    check("halt_state", 64'(state_dbg), 64'(DUMP));
    check("dump_first_valid_low", 64'(out_valid), 64'd0);
    collect_dump(1'b0);
    check("done_cycles_hold", 64'(cycles), 64'd10);
    check("done_status_hold", 64'(status), 64'(HALT));

    // Halt and exception together: halt wins
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_done_clear", 64'(done), 64'd0);
    check("restart_status", 64'(status), 64'(NONE));
    halt = 1'b1;
    exception = 1'b1;
    step();
    halt = 1'b0;
    exception = 1'b0;
    check("both_status", 64'(status), 64'(HALT));
    check("both_cycles", 64'(cycles), 64'd1);
    collect_dump(1'b0);

    // Exception after 3 edges, dump with toggling ready
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    exception = 1'b1;
    step();
    exception = 1'b0;
    check("exc_status", 64'(status), 64'(ILLEGAL));
    check("exc_cycles", 64'(cycles), 64'd4);
    collect_dump(1'b1);
    check("exc_done_status", 64'(status), 64'(ILLEGAL));

    // Reset while beat 12 is pending; start under reset ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    halt = 1'b1;
    step();
    halt = 1'b0;
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid && out_idx == 5'd12) found = 1'b1;
      else step();
    end
    check("reach_beat12", 64'(found), 64'd1);
    rst_ = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(IDLE));
    check("midrst_cycles", 64'(cycles), 64'd0);
    check("midrst_idx", 64'(out_idx), 64'd0);
    check("midrst_cpu_run", 64'(cpu_run), 64'd0);
    rst_ = 1'b0;
    step();
    check("rst_start_ignored", 64'(state_dbg), 64'(IDLE));
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("post_rst_cycles", 64'(cycles), 64'd3);
    collect_dump(1'b0);

    // Saturation: reach all-ones minus 1, then 5 more edges
    start = 1'b1;
    step();
    start = 1'b0;
    step(30);
    check("sat_pre", 64'(cycles), 64'd30);
    step(4);
    check("sat_hold", 64'(cycles), 64'd31);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("sat_final", 64'(cycles), 64'd31);
    check("sat_status", 64'(status), 64'(HALT));
    collect_dump(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
